stream_demux_1ton: RTL and testbench

Parametrised, registered 1-to-N stream demultiplexer with per-channel valid/ready handshake and packet locking. The routing decision is taken on the first beat of a packet and held until the beat flagged last. Each output has a one-entry holding register, so outputs are glitch-free and back-pressure is per channel. Out-of-range selects drop the packet and are counted. Sits between a single producer and N consumer ports; it replaces the combinational 1-to-8 demux.

---
 rtl/stream_demux_pkg.sv | 11 +
 rtl/stream_demux_1ton_slot.sv | 35 +++
 rtl/stream_demux_1ton.sv | 114 +++++++++++
 tb/tb_stream_demux_1ton.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
// Holds the packet-routing FSM state encoding.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

endpackage

// File: rtl/stream_demux_1ton_slot.sv
// One-entry valid/ready holding register for a single demux output channel.
// The slot can drain and refill in the same cycle, so it sustains one beat per cycle.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  input  logic              rd_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              free
);

  assign free = !valid || rd_ready;

  // Output register stage; data is left untouched on drain so it never glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
      last  <= wr_last;
    end else if (rd_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with packet locking, per-channel
// back-pressure and a saturating counter of beats dropped on bad selects.
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 8,
  parameter int SEL_W   = 3,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic                      drop_pulse,
  output logic [CNT_W-1:0]          drop_cnt
);

  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W+1)'(NUM_OUT);

  state_t             state, state_nxt;
  logic [SEL_W-1:0]   lock_sel;
  logic [SEL_W-1:0]   eff_sel;
  logic               sel_ok;
  logic               dropping;
  logic               target_free;
  logic               accept;
  logic               lock_load;
  logic               drop_beat;
  logic [NUM_OUT-1:0] slot_free;
  logic [NUM_OUT-1:0] slot_wr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Routing decision: in_sel steers only the first beat, later beats follow the lock
  always_comb begin
    sel_ok      = ({1'b0, in_sel} < NUM_OUT_L);
    eff_sel     = (state == ST_FWD) ? lock_sel : in_sel;
    dropping    = (state == ST_DROP) || ((state == ST_IDLE) && !sel_ok);
    target_free = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (eff_sel == SEL_W'(k)) target_free = slot_free[k];
    end
    in_ready  = dropping || target_free;
    accept    = in_valid && in_ready;
    drop_beat = accept && dropping;
    for (int k = 0; k < NUM_OUT; k++) begin
      slot_wr[k] = accept && !dropping && (eff_sel == SEL_W'(k));
    end
  end

  always_comb begin
    state_nxt = state;
    lock_load = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && !in_last) begin
          if (sel_ok) begin
            state_nxt = ST_FWD;
            lock_load = 1'b1;
          end else begin
            state_nxt = ST_DROP;
          end
        end
      end
      ST_FWD, ST_DROP: begin
        if (accept && in_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_sel   <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      if (lock_load) lock_sel <= in_sel;
      drop_pulse <= drop_beat;
      if (drop_beat) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (slot_wr[k]),
      .wr_data  (in_data),
      .wr_last  (in_last),
      .rd_ready (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W]),
      .last     (out_last[k]),
      .free     (slot_free[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton with six channels and a 3-bit select,
// so selects 6 and 7 exercise the drop path and a 3-bit counter saturates.
module tb_stream_demux_1ton;

  localparam int DATA_W  = 8;
  localparam int NUM_OUT = 6;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_W-1:0]         in_data;
  logic                      in_last;
  logic [SEL_W-1:0]          in_sel;
  logic [NUM_OUT-1:0]        out_valid;
  logic [NUM_OUT-1:0]        out_ready;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        out_last;
  logic                      drop_pulse;
  logic [CNT_W-1:0]          drop_cnt;

  stream_demux_1ton #(
    .DATA_W (DATA_W),
    .NUM_OUT(NUM_OUT),
    .SEL_W  (SEL_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .drop_pulse(drop_pulse),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int mdl_state = 0;
  int mdl_lock = 0;
  logic [DATA_W:0] q [NUM_OUT][$];
  logic [NUM_OUT-1:0] hold_prev = '0;
  logic [DATA_W-1:0] hold_data [NUM_OUT];
  logic [DATA_W:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_drop();
    exp_pulses++;
    if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endfunction

  function automatic void model_accept(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                                       input logic l);
    int idx;
    idx = int'(sel);
    case (mdl_state)
      0: begin
        if (idx < NUM_OUT) begin
          q[idx].push_back({l, d});
          if (!l) begin
            mdl_lock  = idx;
            mdl_state = 1;
          end
        end else begin
          model_drop();
          if (!l) mdl_state = 2;
        end
      end
      1: begin
        q[mdl_lock].push_back({l, d});
        if (l) mdl_state = 0;
      end
      default: begin
        model_drop();
        if (l) mdl_state = 0;
      end
    endcase
  endfunction

  // Drives one beat and holds it until accepted; returns at posedge+1 with in_valid still high
  task automatic send_beat(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                           input logic l, output int waited);
    logic acc;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    in_last  = l;
    waited   = 0;
    acc      = 1'b0;
    while (!acc) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        model_accept(sel, d, l);
      end else begin
        waited++;
        if (waited > 40) begin
          chk("accept_timeout", 64'd0, 64'd1);
          in_valid = 1'b0;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks held beats stay put
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = '0;
    end else begin
      if (drop_pulse) pulses++;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (hold_prev[k]) begin
          chk($sformatf("hold_valid_ch%0d", k), 64'(out_valid[k]), 64'd1);
          chk($sformatf("hold_data_ch%0d", k), 64'(out_data[k*DATA_W +: DATA_W]), 64'(hold_data[k]));
        end
        if (out_valid[k] && out_ready[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("unexpected_beat_ch%0d", k), 64'(out_data[k*DATA_W +: DATA_W]), 64'hDEAD);
          end else begin
            mon_e = q[k].pop_front();
            chk($sformatf("beat_ch%0d", k), 64'({out_last[k], out_data[k*DATA_W +: DATA_W]}),
                64'(mon_e));
          end
        end
        hold_prev[k] = out_valid[k] && !out_ready[k];
        hold_data[k] = out_data[k*DATA_W +: DATA_W];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_sel    = '0;
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst = 1'b0;

    // Single-beat packets across every select value, back to back
    for (int s = 0; s < 8; s++) begin
      send_beat(SEL_W'(s), 8'hA0 + 8'(s), 1'b1, w);
      chk($sformatf("t1_wait_sel%0d", s), 64'(w), 64'd0);
      chk($sformatf("t1_onehot_sel%0d", s), 64'(out_valid),
          (s < NUM_OUT) ? 64'(1 << s) : 64'd0);
    end
    idle(2);
    chk("t1_drop_cnt", 64'(drop_cnt), 64'(exp_cnt));
    chk("t1_pulses", 64'(pulses), 64'(exp_pulses));

    // Locked packet: later selects are ignored
    send_beat(3'd5, 8'h11, 1'b0, w);
    send_beat(3'd2, 8'h22, 1'b0, w);
    send_beat(3'd2, 8'h33, 1'b0, w);
    send_beat(3'd2, 8'h44, 1'b1, w);
    chk("t2_out_valid", 64'(out_valid), 64'h20);
    chk("t2_out_last5", 64'(out_last[5]), 64'd1);
    send_beat(3'd0, 8'h77, 1'b1, w);
    chk("t2_back_idle", 64'(out_valid), 64'h01);
    idle(2);

    // Back-pressure on channel 3
    out_ready[3] = 1'b0;
    send_beat(3'd3, 8'h31, 1'b0, w);
    in_valid = 1'b1;
    in_data  = 8'h32;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_in_ready_blocked", 64'(in_ready), 64'd0);
      chk("t3_held_data", 64'(out_data[3*DATA_W +: DATA_W]), 64'h31);
    end
    @(posedge clk);
    #1;
    out_ready[3] = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_release", 64'(in_ready), 64'd1);
    if (in_ready) model_accept(3'd3, 8'h32, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t3_second_valid", 64'(out_valid[3]), 64'd1);
    chk("t3_second_data", 64'(out_data[3*DATA_W +: DATA_W]), 64'h32);
    idle(2);

    // Out-of-range multi-beat packet is swallowed
    for (int i = 0; i < 3; i++) begin
      send_beat(3'd7, 8'(8'h90 + i), (i == 2), w);
      chk("t4_wait", 64'(w), 64'd0);
      chk("t4_no_out", 64'(out_valid), 64'd0);
    end
    idle(2);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd5);
    chk("t4_pulses", 64'(pulses), 64'(exp_pulses));

    // Counter saturation
    for (int i = 0; i < 5; i++) send_beat(3'd6, 8'(i), 1'b1, w);
    idle(2);
    chk("t6_drop_cnt_sat", 64'(drop_cnt), 64'd7);
    chk("t6_drop_cnt_model", 64'(drop_cnt), 64'(exp_cnt));
    chk("t6_pulses", 64'(pulses), 64'(exp_pulses));

    // Reset in the middle of a locked packet
    out_ready[1] = 1'b0;
    send_beat(3'd1, 8'h55, 1'b0, w);
    chk("t5_held", 64'(out_valid), 64'h02);
    rst      = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) q[k].delete();
    mdl_state = 0;
    exp_cnt   = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = '1;
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_drop_cnt", 64'(drop_cnt), 64'd0);
    send_beat(3'd4, 8'h66, 1'b1, w);
    chk("t5_route4", 64'(out_valid), 64'h10);
    chk("t5_data4", 64'(out_data[4*DATA_W +: DATA_W]), 64'h66);
    idle(4);

    for (int k = 0; k < NUM_OUT; k++)
      chk($sformatf("drained_ch%0d", k), 64'(q[k].size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
